aes_columns_mixer_iter: RTL and testbench
=========================================

# aes_columns_mixer_iter

Parametrised, handshaked successor of the combinational AES MixColumns/InvMixColumns stage. It accepts a 128-bit state block with a per-block direction flag and mixes `LANES` columns per clock over `4/LANES` cycles. The result is held in an output register until the consumer accepts it. The block sits between the ShiftRows and AddRoundKey stages of iterative AES round cores, where area matters more than single-cycle throughput.

## Interface
- `LANES`, default 4: columns mixed per cycle. Legal values are 1, 2 and 4; any other value triggers an elaboration-time `$error`.
- `Clk`  in  1  single clock; all state updates on the rising edge.
- `Rst_n`  in  1  reset, asynchronous and active-low; clears all state.
- `In_valid`  in  1  the input block is presented.
- `In_ready`  out  1  the block can accept input this cycle.
- `In_encrypt`  in  1  1 selects MixColumns, 0 selects InvMixColumns; sampled only on input acceptance.
- `In_block`  in  `AES_BLOCK_SIZE` (128)  state block.
- `Out_valid`  out  1  `Out_block` holds a finished result.
- `Out_ready`  in  1  the consumer accepts the result.
- `Out_block`  out  128  mixed block.
- `Busy`  out  1  the block is not in IDLE.

## Operation
- Layout:
  - Column c occupies bits [32c+31 : 32c].
  - Row r of column c occupies bits [32c+8r+7 : 32c+8r].
- Per-column math, all in GF(2^8) with reduction polynomial 0x11B; a_r is the row-r byte of the input column, out_r the row-r byte of the result:
  - Encrypt: out_r = 02·a_r ^ 03·a_(r+1) ^ a_(r+2) ^ a_(r+3), indices mod 4.
  - Decrypt: out_r = 0E·a_r ^ 0B·a_(r+1) ^ 0D·a_(r+2) ^ 09·a_(r+3), indices mod 4.
- Internal state:
  - 128-bit work register.
  - Mode register.
  - Column counter `col`, width 2 bits, counting in steps of `LANES`.
- FSM states: IDLE, MIX, HOLD.
- IDLE:
  - `In_ready`=1.
  - On `In_valid`: load `In_block` into the work register, latch `In_encrypt`, set `col`=0, go to MIX.
- MIX:
  - Each cycle, columns `col` .. `col+LANES-1` of the work register are replaced in place by their mixed values.
  - `col` += `LANES`.
  - When the last group is written, go to HOLD.
  - `In_ready`=0.
- HOLD:
  - `Out_valid`=1 and `Out_block` = work register.
  - `In_ready` = `Out_ready`.
  - If `Out_ready` and `In_valid`: the new block is loaded in the same cycle (back-to-back), go to MIX.
  - If `Out_ready` and not `In_valid`: go to IDLE.
  - Otherwise stay in HOLD with `Out_block` stable.
- `Out_block` is driven from the work register in every state. It is meaningful only while `Out_valid` is 1.
- `In_encrypt` and `In_block` are don't-care whenever no input acceptance occurs.
- Reset mid-operation: any block in flight is discarded and no output is produced for it.

## Timing
- Reset values:
  - State = IDLE.
  - `In_ready`=1, `Out_valid`=0, `Busy`=0.
  - `Out_block`=0, `col`=0, mode=1.
- Latency: input accepted at edge t gives `Out_valid`=1 after edge t+`4/LANES`. That is 1, 2 or 4 cycles for `LANES`=4, 2, 1.
- Throughput with a back-to-back stream and `Out_ready` held at 1: one block per `4/LANES`+1 cycles.
- Output handshake:
  - `Out_valid` never deasserts without `Out_ready`.
  - `Out_block` is stable while `Out_valid` is 1 and `Out_ready` is 0.
- `In_ready` is combinational from state and `Out_ready`. There is no path from `In_valid` to `In_ready`.
- `Busy` = (state != IDLE), registered-state decode.

## Structure
- Shared `aes_pkg` (or `aes_defines.svh` if the package is not yet split):
  - `AES_BLOCK_SIZE`, `AES_WORD_SIZE`.
  - gmul functions for 02/03/09/0B/0D/0E.
  - Per-word `mix_enc`/`mix_dec` functions, shared with the combinational mixer so both use one implementation.
  - FSM state enum `aes_mix_state_t`.
- One sub-module, `aes_column_mixer_word`:
  - Ports: `Encrypt`, a 32-bit input word and a 32-bit output word.
  - Purely combinational.
  - Instantiated `LANES` times by a generate loop.
  - Lane k mixes column `col+k`; input selection is a mux on `col`.

## Test plan
- Encrypt, all `LANES`: each column 32'h455313db -> each output column 32'hbca14d8e. Columns 32'h5c220af2 -> 32'h9d58dc9f in the same block.
- Decrypt: the input 32'hbca14d8e x4 with `In_encrypt`=0 -> 32'h455313db x4.
- Fixed points:
  - 32'h01010101 -> 32'h01010101 in both modes.
  - 32'hc6c6c6c6 -> 32'hc6c6c6c6 in both modes.
- Back-pressure: hold `Out_ready`=0 for 5 cycles in HOLD. `Out_valid` stays 1, `Out_block` is unchanged and `In_ready`=0. Release with `In_valid`=1: the next block is accepted in the same cycle.
- Back-to-back stream of 8 random blocks with alternating mode, `LANES`=1 and 4, checked against a reference model:
  - Output order and mode are preserved per block.
  - Cycle spacing is exactly `4/LANES`+1.
- Assert `Rst_n`=0 mid-MIX (`LANES`=1, `col`=2):
  - Outputs go to reset values immediately, asynchronously.
  - No `Out_valid` appears after release.
  - The first subsequent block mixes correctly.

Source files
------------

// File: rtl/aes_columns_mixer_iter_pkg.sv
// aes_columns_mixer_iter_pkg: AES sizes, GF(2^8) multipliers, per-word MixColumns math and mixer FSM states
package aes_columns_mixer_iter_pkg;
   localparam int AES_BLOCK_SIZE = 128;
   localparam int AES_WORD_SIZE = 32;
   typedef enum logic [1:0] {IDLE, MIX, HOLD} aes_mix_state_t;
   function automatic logic [7:0] gmul02(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction
   function automatic logic [7:0] gmul03(input logic [7:0] a);
      return gmul02(a) ^ a;
   endfunction
   function automatic logic [7:0] gmul09(input logic [7:0] a);
      return gmul02(gmul02(gmul02(a))) ^ a;
   endfunction
   function automatic logic [7:0] gmul0b(input logic [7:0] a);
      return gmul02(gmul02(gmul02(a))) ^ gmul02(a) ^ a;
   endfunction
   function automatic logic [7:0] gmul0d(input logic [7:0] a);
      return gmul02(gmul02(gmul02(a))) ^ gmul02(gmul02(a)) ^ a;
   endfunction
   function automatic logic [7:0] gmul0e(input logic [7:0] a);
      return gmul02(gmul02(gmul02(a))) ^ gmul02(gmul02(a)) ^ gmul02(a);
   endfunction
   function automatic logic [AES_WORD_SIZE-1:0] mix_enc(input logic [AES_WORD_SIZE-1:0] w);
      logic [AES_WORD_SIZE-1:0] o;
      for (int r = 0; r < 4; r++)
         o[8*r +: 8] = gmul02(w[8*r +: 8]) ^ gmul03(w[8*((r+1)%4) +: 8]) ^ w[8*((r+2)%4) +: 8] ^ w[8*((r+3)%4) +: 8];
      return o;
   endfunction
   function automatic logic [AES_WORD_SIZE-1:0] mix_dec(input logic [AES_WORD_SIZE-1:0] w);
      logic [AES_WORD_SIZE-1:0] o;
      for (int r = 0; r < 4; r++)
         o[8*r +: 8] = gmul0e(w[8*r +: 8]) ^ gmul0b(w[8*((r+1)%4) +: 8]) ^ gmul0d(w[8*((r+2)%4) +: 8]) ^ gmul09(w[8*((r+3)%4) +: 8]);
      return o;
   endfunction
endpackage

// File: rtl/aes_columns_mixer_iter_if.sv
// aes_columns_mixer_iter_if: input/output valid-ready handshake of the iterative column mixer
interface aes_columns_mixer_iter_if;
   import aes_columns_mixer_iter_pkg::*;
   logic In_valid;
   logic In_ready;
   logic In_encrypt;
   logic [AES_BLOCK_SIZE-1:0] In_block;
   logic Out_valid;
   logic Out_ready;
   logic [AES_BLOCK_SIZE-1:0] Out_block;
   modport master (output In_valid, In_encrypt, In_block, Out_ready, input In_ready, Out_valid, Out_block);
   modport slave (input In_valid, In_encrypt, In_block, Out_ready, output In_ready, Out_valid, Out_block);
endinterface

// File: rtl/aes_column_mixer_word.sv
// aes_column_mixer_word: combinational MixColumns/InvMixColumns of one 32-bit column
module aes_column_mixer_word
   import aes_columns_mixer_iter_pkg::*;
(
   input  logic Encrypt,
   input  logic [AES_WORD_SIZE-1:0] In_word,
   output logic [AES_WORD_SIZE-1:0] Out_word
);
   assign Out_word = Encrypt ? mix_enc(In_word) : mix_dec(In_word);
endmodule

// File: rtl/aes_columns_mixer_iter.sv
// aes_columns_mixer_iter: handshaked AES (Inv)MixColumns mixing LANES columns per cycle in place
module aes_columns_mixer_iter
   import aes_columns_mixer_iter_pkg::*;
#(
   parameter int LANES = 4
) (
   input  logic Clk,
   input  logic Rst_n,
   aes_columns_mixer_iter_if.slave bus,
   output logic Busy
);
   localparam logic [1:0] STEP = 2'(LANES);
   localparam logic [1:0] LAST = 2'(4 - LANES);
   if (LANES != 1 && LANES != 2 && LANES != 4) begin : g_bad_lanes
      $error("aes_columns_mixer_iter: LANES must be 1, 2 or 4, got %0d", LANES);
   end
   aes_mix_state_t state, nxt;
   logic [AES_BLOCK_SIZE-1:0] work, mixed;
   logic mode, accept;
   logic [1:0] col;
   logic [1:0] sel [LANES];
   logic [AES_WORD_SIZE-1:0] lane_in [LANES];
   logic [AES_WORD_SIZE-1:0] lane_out [LANES];
   for (genvar k = 0; k < LANES; k++) begin : g_lane
      assign sel[k] = col + 2'(k);
      assign lane_in[k] = work[AES_WORD_SIZE*sel[k] +: AES_WORD_SIZE];
      aes_column_mixer_word u_word (.Encrypt(mode), .In_word(lane_in[k]), .Out_word(lane_out[k]));
   end
   // work register with the current column group replaced by its mixed value
   always_comb begin
      mixed = work;
      for (int k = 0; k < LANES; k++) mixed[AES_WORD_SIZE*sel[k] +: AES_WORD_SIZE] = lane_out[k];
   end
   // handshake decode and next state; HOLD frees up as soon as the consumer takes the result
   always_comb begin
      bus.In_ready = (state == IDLE) || (state == HOLD && bus.Out_ready);
      accept = bus.In_ready && bus.In_valid;
      nxt = state == MIX ? (col == LAST ? HOLD : MIX) : accept ? MIX : (state == HOLD && !bus.Out_ready) ? HOLD : IDLE;
   end
   assign bus.Out_valid = state == HOLD;
   assign bus.Out_block = work;
   assign Busy = state != IDLE;
   // state, work register, mode and column counter
   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         state <= IDLE;
         work <= '0;
         mode <= 1'b1;
         col <= '0;
      end else begin
         state <= nxt;
         if (accept) begin
            work <= bus.In_block;
            mode <= bus.In_encrypt;
            col <= '0;
         end else if (state == MIX) begin
            work <= mixed;
            col <= col + STEP;
         end
      end
   end
endmodule

// File: tb/tb_aes_columns_mixer_iter.sv
// tb_aes_columns_mixer_iter: directed and streamed checks of the column mixer for LANES = 1, 2, 4
module tb_aes_columns_mixer_iter;
   typedef struct {
      logic enc;
      logic [127:0] blk;
      logic [127:0] exp;
   } vec_t;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic in_valid [3];
   logic in_encrypt [3];
   logic out_ready [3];
   logic [127:0] in_block [3];
   logic in_ready [3];
   logic out_valid [3];
   logic busy [3];
   logic [127:0] out_block [3];
   int total = 0;
   int bad = 0;
   vec_t vecs [8];
   always #5 clk = ~clk;
   for (genvar g = 0; g < 3; g++) begin : g_cfg
      aes_columns_mixer_iter_if ifc ();
      assign ifc.In_valid = in_valid[g];
      assign ifc.In_encrypt = in_encrypt[g];
      assign ifc.In_block = in_block[g];
      assign ifc.Out_ready = out_ready[g];
      assign in_ready[g] = ifc.In_ready;
      assign out_valid[g] = ifc.Out_valid;
      assign out_block[g] = ifc.Out_block;
      aes_columns_mixer_iter #(.LANES(1 << g)) dut (.Clk(clk), .Rst_n(rst_n), .bus(ifc), .Busy(busy[g]));
   end
   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask
   function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p, x;
      p = 8'h00;
      x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      end
      return p;
   endfunction
   function automatic logic [127:0] ref_mix(input logic [127:0] b, input logic enc);
      logic [7:0] cf [4];
      logic [7:0] o;
      logic [127:0] r;
      if (enc) cf = '{8'h02, 8'h03, 8'h01, 8'h01};
      else cf = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
      r = '0;
      for (int c = 0; c < 4; c++)
         for (int rr = 0; rr < 4; rr++) begin
            o = 8'h00;
            for (int j = 0; j < 4; j++) o = o ^ gm(b[32*c + 8*((rr+j)%4) +: 8], cf[j]);
            r[32*c + 8*rr +: 8] = o;
         end
      return r;
   endfunction
   task automatic send(input int c, input logic enc, input logic [127:0] blk);
      @(negedge clk);
      in_valid[c] = 1'b1;
      in_encrypt[c] = enc;
      in_block[c] = blk;
      @(negedge clk);
      in_valid[c] = 1'b0;
      in_block[c] = {$urandom, $urandom, $urandom, $urandom};
   endtask
   task automatic wait_out(input int c, output int n);
      n = 0;
      while (!out_valid[c] && n < 40) begin
         @(negedge clk);
         n++;
      end
   endtask
   task automatic take(input int c);
      out_ready[c] = 1'b1;
      @(negedge clk);
      out_ready[c] = 1'b0;
   endtask
   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, total=%0d", total);
      $fatal(1);
   end
   initial begin
      int n, idx, got, cyc, prev, cnt;
      logic acc;
      logic [127:0] blks [8];
      logic encs [8];
      for (int c = 0; c < 3; c++) begin
         in_valid[c] = 1'b0;
         in_encrypt[c] = 1'b0;
         in_block[c] = '0;
         out_ready[c] = 1'b0;
      end
      vecs[0] = '{1'b1, {4{32'h455313db}}, {4{32'hbca14d8e}}};
      vecs[1] = '{1'b1, {32'h5c220af2, 32'h455313db, 32'h5c220af2, 32'h455313db},
                        {32'h9d58dc9f, 32'hbca14d8e, 32'h9d58dc9f, 32'hbca14d8e}};
      vecs[2] = '{1'b0, {4{32'hbca14d8e}}, {4{32'h455313db}}};
      vecs[3] = '{1'b1, {4{32'h01010101}}, {4{32'h01010101}}};
      vecs[4] = '{1'b0, {4{32'h01010101}}, {4{32'h01010101}}};
      vecs[5] = '{1'b1, {4{32'hc6c6c6c6}}, {4{32'hc6c6c6c6}}};
      vecs[6] = '{1'b0, {4{32'hc6c6c6c6}}, {4{32'hc6c6c6c6}}};
      vecs[7] = '{1'b0, {4{32'h9d58dc9f}}, {4{32'h5c220af2}}};
      repeat (2) @(negedge clk);
      for (int c = 0; c < 3; c++) begin
         chk($sformatf("rst in_ready c%0d", c), 128'(in_ready[c]), 128'd1);
         chk($sformatf("rst out_valid c%0d", c), 128'(out_valid[c]), 128'd0);
         chk($sformatf("rst busy c%0d", c), 128'(busy[c]), 128'd0);
         chk($sformatf("rst out_block c%0d", c), out_block[c], 128'd0);
      end
      rst_n = 1'b1;
      for (int c = 0; c < 3; c++)
         for (int i = 0; i < 8; i++) begin
            send(c, vecs[i].enc, vecs[i].blk);
            wait_out(c, n);
            chk($sformatf("latency c%0d v%0d", c, i), 128'(n), 128'(4 >> c));
            chk($sformatf("result c%0d v%0d", c, i), out_block[c], vecs[i].exp);
            take(c);
         end
      for (int c = 0; c < 3; c++) begin
         send(c, vecs[0].enc, vecs[0].blk);
         wait_out(c, n);
         for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk($sformatf("bp out_valid c%0d t%0d", c, i), 128'(out_valid[c]), 128'd1);
            chk($sformatf("bp out_block c%0d t%0d", c, i), out_block[c], vecs[0].exp);
            chk($sformatf("bp in_ready c%0d t%0d", c, i), 128'(in_ready[c]), 128'd0);
         end
         out_ready[c] = 1'b1;
         in_valid[c] = 1'b1;
         in_encrypt[c] = vecs[2].enc;
         in_block[c] = vecs[2].blk;
         #1;
         chk($sformatf("bp release in_ready c%0d", c), 128'(in_ready[c]), 128'd1);
         @(negedge clk);
         out_ready[c] = 1'b0;
         in_valid[c] = 1'b0;
         chk($sformatf("bp reload busy c%0d", c), 128'(busy[c]), 128'd1);
         chk($sformatf("bp reload out_valid c%0d", c), 128'(out_valid[c]), 128'd0);
         wait_out(c, n);
         chk($sformatf("bp reload latency c%0d", c), 128'(n), 128'(4 >> c));
         chk($sformatf("bp reload result c%0d", c), out_block[c], vecs[2].exp);
         take(c);
      end
      for (int c = 0; c < 3; c++) begin
         for (int i = 0; i < 8; i++) begin
            blks[i] = {$urandom, $urandom, $urandom, $urandom};
            encs[i] = logic'(i % 2);
         end
         @(negedge clk);
         idx = 0;
         got = 0;
         cyc = 0;
         prev = 0;
         in_valid[c] = 1'b1;
         in_encrypt[c] = encs[0];
         in_block[c] = blks[0];
         out_ready[c] = 1'b1;
         while (got < 8 && cyc < 200) begin
            if (out_valid[c]) begin
               chk($sformatf("stream data c%0d b%0d", c, got), out_block[c], ref_mix(blks[got], encs[got]));
               if (got > 0) chk($sformatf("stream spacing c%0d b%0d", c, got), 128'(cyc - prev), 128'((4 >> c) + 1));
               prev = cyc;
               got++;
            end
            acc = in_valid[c] && in_ready[c];
            @(posedge clk);
            #1;
            if (acc) begin
               idx++;
               in_valid[c] = idx < 8;
               if (idx < 8) begin
                  in_block[c] = blks[idx];
                  in_encrypt[c] = encs[idx];
               end
            end
            @(negedge clk);
            cyc++;
         end
         chk($sformatf("stream count c%0d", c), 128'(got), 128'd8);
         in_valid[c] = 1'b0;
         out_ready[c] = 1'b0;
      end
      send(0, vecs[0].enc, vecs[0].blk);
      repeat (2) @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk("async rst busy", 128'(busy[0]), 128'd0);
      chk("async rst out_valid", 128'(out_valid[0]), 128'd0);
      chk("async rst in_ready", 128'(in_ready[0]), 128'd1);
      chk("async rst out_block", out_block[0], 128'd0);
      @(negedge clk);
      rst_n = 1'b1;
      cnt = 0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (out_valid[0]) cnt++;
      end
      chk("post rst no out_valid", 128'(cnt), 128'd0);
      send(0, vecs[7].enc, vecs[7].blk);
      wait_out(0, n);
      chk("post rst latency", 128'(n), 128'd4);
      chk("post rst result", out_block[0], vecs[7].exp);
      take(0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
